// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift master: FSM state encoding,
// SPI mode constants {CPOL, CPHA} and a mode helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Modes 0 and 2 sample on the leading SCLK edge, 1 and 3 on the trailing.
    function automatic logic lead_sample(input logic [1:0] mode);
        logic r;
        r = 1'b0;
        unique case (mode)
            MODE0, MODE2: r = 1'b1;
            MODE1, MODE3: r = 1'b0;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_shift_master_if.sv
// Bus bundle of the SPI shift master: start/busy/done handshake, words
// in and out, and the SPI pins. master = engine side, slave = user side.
interface spi_shift_master_if #(
    parameter int WIDTH = 40
);
    logic             start_in;
    logic [WIDTH-1:0] data_in;
    logic             miso_in;
    logic [WIDTH-1:0] data_out;
    logic             busy_out;
    logic             done_out;
    logic             sclk_out;
    logic             mosi_out;
    logic             cs_n_out;

    modport master (
        input  start_in, data_in, miso_in,
        output data_out, busy_out, done_out,
        output sclk_out, mosi_out, cs_n_out
    );

    modport slave (
        output start_in, data_in, miso_in,
        input  data_out, busy_out, done_out,
        input  sclk_out, mosi_out, cs_n_out
    );
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period tick enable: counts CLK_DIV-1 down to 0, ticks at 0.
// Ports: clk, rst_n (async, active low), load (sync restart), tick.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else if (load || cnt_q == '0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/spi_shift_master.sv
// Full-duplex SPI shift master with configurable width, bit order, mode
// and SCLK divider. Ports: clk_in, rst_n_in (async, active low), bus.
module spi_shift_master
    import spi_pkg::*;
#(
    parameter int WIDTH     = 40,
    parameter int CLK_DIV   = 4,
    parameter bit CPOL      = 1'b1,
    parameter bit CPHA      = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    spi_shift_master_if.master bus
);
    localparam logic [1:0] MODE = {CPOL, CPHA};
    localparam bit LEAD_SAMPLE = lead_sample(MODE);
    localparam int EW = $clog2(2 * WIDTH) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);

    state_t           state_q, state_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick, load;
    logic             lead, sample, drive;

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                  input logic b);
        return MSB_FIRST ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
    endfunction

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .load  (load),
        .tick  (tick)
    );

    // Every state change restarts the half-period count.
    assign load = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lead    = ~edge_q[0];
        sample  = LEAD_SAMPLE ? lead : ~lead;
        // Drive on the non-sampling edge; never on the final edge.
        drive   = ~sample && (edge_q != LAST_EDGE);
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                sclk_d = CPOL;
                busy_d = 1'b0;
                if (bus.start_in) begin
                    tx_d    = bus.data_in;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cs_n_d = 1'b0;
                edge_d = '0;
                // Leading-edge sampling needs the first bit out before
                // any edge; cs_n_q still high marks the first cycle.
                if (LEAD_SAMPLE && cs_n_q) begin
                    mosi_d = first_bit(tx_q);
                    tx_d   = shift_out(tx_q);
                end
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (drive) begin
                        mosi_d = first_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end
                    if (sample) rx_d = shift_in(rx_q, bus.miso_in);
                    if (edge_q == LAST_EDGE) state_d = HOLD;
                    else edge_d = edge_q + EW'(1);
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
    assign bus.sclk_out = sclk_q;
    assign bus.mosi_out = mosi_q;
    assign bus.cs_n_out = cs_n_q;
endmodule
